lcd_frame_capture: RTL

- Consumer end of the PPU pixel stream: accepts 2-bit pixels on PX_OUT/PX_valid, packs four pixels per byte, and writes complete 160x144 frames into a double-buffered framebuffer RAM.
- Sits between the PPU and the video-output/display reader. The reader always scans the bank indicated by FRONT_BANK while the PPU fills the other bank.
- Frame alignment is taken from PPU_MODE entering V-blank (mode 1).

---
 rtl/lcd_frame_capture.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/lcd_frame_capture.sv
// Captures the PPU 2-bit pixel stream, packs four pixels per byte (MSB first) and
// writes whole frames into a double-buffered framebuffer, swapping banks on completion.
module lcd_frame_capture #(
    parameter int H_PIXELS = 160,
    parameter int V_LINES  = 144,
    parameter int ADDR_W   = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        PX_OUT,
    input  logic              PX_valid,
    input  logic [1:0]        PPU_MODE,
    input  logic              ERR_CLR,
    output logic              FB_WR,
    output logic [ADDR_W:0]   FB_ADDR,
    output logic [7:0]        FB_DATA,
    output logic              FRONT_BANK,
    output logic              FRAME_DONE,
    output logic              SHORT_FRAME,
    output logic              OVERRUN
);

    localparam int TOTAL = H_PIXELS * V_LINES;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam logic [CNT_W-1:0] CNT_FULL    = CNT_W'(TOTAL);
    localparam logic [1:0]       MODE_VBLANK = 2'd1;

    function automatic logic [7:0] insert_px(
        input logic [7:0] acc,
        input logic [1:0] slot,
        input logic [1:0] px
    );
        logic [7:0] res;
        res = acc;
        case (slot)
            2'd0:    res[7:6] = px;
            2'd1:    res[5:4] = px;
            2'd2:    res[3:2] = px;
            default: res[1:0] = px;
        endcase
        return res;
    endfunction

    logic [CNT_W-1:0]  count_p0;
    logic [ADDR_W-1:0] idx_p0;
    logic [7:0]        pack_p0;
    logic              back_p0;
    logic              front_p0;
    logic [1:0]        prev_mode_p0;

    logic              vld_p1;
    logic [ADDR_W:0]   addr_p1;
    logic [7:0]        data_p1;
    logic              done_p1;
    logic              short_flag;
    logic              overrun_flag;

    logic              in_vblank;
    logic              vblank_entry;
    logic              frame_full;
    logic              accept;
    logic              drop;
    logic              byte_end;
    logic              frame_end;
    logic              short_set;
    logic [CNT_W-1:0]  count_nx;
    logic [7:0]        packed_byte;

    always_comb begin
        in_vblank    = (PPU_MODE == MODE_VBLANK);
        vblank_entry = in_vblank && (prev_mode_p0 != MODE_VBLANK);
        frame_full   = (count_p0 == CNT_FULL);
        accept       = PX_valid && !in_vblank && !frame_full;
        drop         = PX_valid && !in_vblank && frame_full;
        byte_end     = accept && (count_p0[1:0] == 2'd3);
        count_nx     = count_p0 + CNT_W'(1);
        frame_end    = accept && (count_nx == CNT_FULL);
        // An empty frame (LCD off) is not an error; only a started, unfinished one is.
        short_set    = vblank_entry && (count_p0 != '0) && !frame_full;
        packed_byte  = insert_px(pack_p0, count_p0[1:0], PX_OUT);
    end

    // ---- Stage p0: pixel accumulation, frame position and bank ownership ----
    always_ff @(posedge clk) begin
        if (rst) begin
            count_p0     <= '0;
            idx_p0       <= '0;
            pack_p0      <= '0;
            back_p0      <= 1'b1;
            front_p0     <= 1'b0;
            prev_mode_p0 <= MODE_VBLANK;
        end else begin
            prev_mode_p0 <= PPU_MODE;
            if (vblank_entry) begin
                count_p0 <= '0;
                idx_p0   <= '0;
                pack_p0  <= '0;
            end else if (accept) begin
                count_p0 <= count_nx;
                if (byte_end) begin
                    idx_p0  <= idx_p0 + ADDR_W'(1);
                    pack_p0 <= '0;
                end else begin
                    pack_p0 <= packed_byte;
                end
                if (frame_end) begin
                    front_p0 <= back_p0;
                    back_p0  <= front_p0;
                end
            end
        end
    end

    // ---- Stage p1: framebuffer write port and completion pulse ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            addr_p1 <= '0;
            data_p1 <= '0;
            done_p1 <= 1'b0;
        end else begin
            vld_p1  <= byte_end;
            done_p1 <= frame_end;
            // Address/data hold their last value between strobes.
            if (byte_end) begin
                addr_p1 <= {back_p0, idx_p0};
                data_p1 <= packed_byte;
            end
        end
    end

    // Sticky error flags: a set event in the same cycle beats ERR_CLR.
    always_ff @(posedge clk) begin
        if (rst) begin
            short_flag   <= 1'b0;
            overrun_flag <= 1'b0;
        end else begin
            if (short_set) begin
                short_flag <= 1'b1;
            end else if (ERR_CLR) begin
                short_flag <= 1'b0;
            end
            if (drop) begin
                overrun_flag <= 1'b1;
            end else if (ERR_CLR) begin
                overrun_flag <= 1'b0;
            end
        end
    end

    assign FB_WR       = vld_p1;
    assign FB_ADDR     = addr_p1;
    assign FB_DATA     = data_p1;
    assign FRONT_BANK  = front_p0;
    assign FRAME_DONE  = done_p1;
    assign SHORT_FRAME = short_flag;
    assign OVERRUN     = overrun_flag;

endmodule
